resource_lock_scheduler: RTL and testbench

- Grants exclusive locks on a pool of NUM_UNITS identical execution units (ALU/MDU/mem bank) to NUM_PORTS SIC requesters.
- Priority is oldest issue ID first, compared wrap-aware.
- Sits between the SIC array and a unit pool. Drives per-port grant plus unit index and holds each lock until the SIC releases it or a rollback flushes.

---
 rtl/resource_lock_scheduler.sv | 159 +++++++++++++++
 tb/tb_resource_lock_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/resource_lock_scheduler.sv
// Age-ordered lock scheduler: grants exclusive units from a pool to SIC requesters, oldest issue ID first.
// Optional lock watchdog enabled by defining RESOURCE_LOCK_TIMEOUT_EN.
module resource_lock_scheduler #(
  parameter int NUM_PORTS      = 8,
  parameter int NUM_UNITS      = 4,
  parameter int ID_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_PORTS-1:0]               req_valid,
  input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] req_id,
  input  logic [NUM_PORTS-1:0]               lock_release,
  input  logic                               flush,
  output logic [NUM_PORTS-1:0]               grant,
  output logic [NUM_PORTS-1:0][UW-1:0]       grant_unit,
  output logic [NUM_UNITS-1:0]               unit_busy,
  output logic                               timeout_err
);

  // Handshake: a port raises req_valid with its req_id and keeps both stable
  // until it observes grant; the lock then stays until a lock_release pulse,
  // flush, or (watchdog builds) a timeout reclaim.

  logic [NUM_PORTS-1:0]         holds_q, holds_n;
  logic [NUM_PORTS-1:0][UW-1:0] port_unit_q, port_unit_n;
  logic [NUM_UNITS-1:0]         busy_q, busy_n;
  logic [NUM_UNITS-1:0][PW-1:0] owner_q, owner_n;
  logic [NUM_UNITS-1:0]         expire;
  logic [NUM_PORTS-1:0]         eligible;
  logic [NUM_PORTS-1:0]         taken;
  logic [PW-1:0]                best;
  logic                         found;

  // a is older than b when (a - b) mod 2^ID_WIDTH has its top bit set.
  function automatic logic is_older(input logic [ID_WIDTH-1:0] a,
                                    input logic [ID_WIDTH-1:0] b);
    logic [ID_WIDTH-1:0] d;
    d = a - b;
    return d[ID_WIDTH-1];
  endfunction

  always_comb begin
    holds_n     = holds_q;
    port_unit_n = port_unit_q;
    busy_n      = busy_q;
    owner_n     = owner_q;
    eligible    = '0;
    taken       = '0;
    best        = '0;
    found       = 1'b0;

    for (int p = 0; p < NUM_PORTS; p++) begin
      if (holds_q[p] && lock_release[p]) begin
        holds_n[p] = 1'b0;
        busy_n[port_unit_q[p]] = 1'b0;
      end
      eligible[p] = req_valid[p] && !holds_q[p] && !lock_release[p];
    end

    for (int u = 0; u < NUM_UNITS; u++) begin
      if (expire[u]) begin
        busy_n[u] = 1'b0;
        holds_n[owner_q[u]] = 1'b0;
      end
    end

    // Free units are taken from the registered busy bits, so a unit freed
    // this cycle is only handed out again next cycle. Strict comparison
    // keeps the lower port index on equal IDs.
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (!busy_q[u]) begin
        found = 1'b0;
        best  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (eligible[p] && !taken[p]) begin
            if (!found || is_older(req_id[p], req_id[best])) begin
              best  = PW'(p);
              found = 1'b1;
            end
          end
        end
        if (found) begin
          taken[best]       = 1'b1;
          holds_n[best]     = 1'b1;
          port_unit_n[best] = UW'(u);
          busy_n[u]         = 1'b1;
          owner_n[u]        = best;
        end
      end
    end

    if (flush) begin
      holds_n = '0;
      busy_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holds_q     <= '0;
      port_unit_q <= '0;
      busy_q      <= '0;
      owner_q     <= '0;
    end else begin
      holds_q     <= holds_n;
      port_unit_q <= port_unit_n;
      busy_q      <= busy_n;
      owner_q     <= owner_n;
    end
  end

`ifdef RESOURCE_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [NUM_UNITS-1:0][CW-1:0] hold_cnt_q;
  logic                         timeout_err_q;

  // A release in the same cycle as the limit wins over the reclaim.
  always_comb begin
    expire = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      expire[u] = busy_q[u] && (hold_cnt_q[u] == CW'(TIMEOUT_CYCLES))
                  && !lock_release[owner_q[u]] && !flush;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else if (flush) begin
      hold_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= |expire;
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (!busy_q[u] && busy_n[u]) begin
          hold_cnt_q[u] <= '0;
        end else if (busy_q[u] && hold_cnt_q[u] != CW'(TIMEOUT_CYCLES)) begin
          hold_cnt_q[u] <= hold_cnt_q[u] + 1'b1;
        end
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign expire      = '0;
  assign timeout_err = 1'b0;
`endif

  assign grant      = holds_q;
  assign grant_unit = port_unit_q;
  assign unit_busy  = busy_q;

endmodule

// File: tb/tb_resource_lock_scheduler.sv
// Directed bench for resource_lock_scheduler: 4 ports, 2 units, 4-bit IDs.
// Watchdog scenario is included when RESOURCE_LOCK_TIMEOUT_EN is defined.
module tb_resource_lock_scheduler;

  localparam int NP = 4;
  localparam int NU = 2;
  localparam int IW = 4;

  logic                  clk;
  logic                  rst_n;
  logic [NP-1:0]         req_valid;
  logic [NP-1:0][IW-1:0] req_id;
  logic [NP-1:0]         lock_release;
  logic                  flush;
  logic [NP-1:0]         grant;
  logic [NP-1:0][0:0]    grant_unit;
  logic [NU-1:0]         unit_busy;
  logic                  timeout_err;

  int checks = 0;
  int errors = 0;

  resource_lock_scheduler #(
    .NUM_PORTS(NP), .NUM_UNITS(NU), .ID_WIDTH(IW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_id(req_id),
    .lock_release(lock_release), .flush(flush), .grant(grant),
    .grant_unit(grant_unit), .unit_busy(unit_busy), .timeout_err(timeout_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_id = '0; lock_release = '0; flush = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    do_reset();
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_busy", 32'(unit_busy), 32'h0);
    check("reset_unit", 32'(grant_unit), 32'h0);
    check("reset_terr", 32'(timeout_err), 32'h0);

    // age order: IDs 5,3,7,4 -> ports 1 and 3 win
    req_id[0] = 4'd5; req_id[1] = 4'd3; req_id[2] = 4'd7; req_id[3] = 4'd4;
    req_valid = 4'b1111;
    step();
    req_valid = 4'b0101;
    check("age_grant", 32'(grant), 32'hA);
    check("age_unit_p1", 32'(grant_unit[1]), 32'h0);
    check("age_unit_p3", 32'(grant_unit[3]), 32'h1);
    check("age_busy", 32'(unit_busy), 32'h3);

    // release port1; unit 0 regranted to port0 (id 5 older than 7) one cycle later
    lock_release = 4'b0010;
    step();
    lock_release = '0;
    check("rel_grant", 32'(grant), 32'h8);
    check("rel_busy", 32'(unit_busy), 32'h2);
    step();
    req_valid = 4'b0100;
    check("regrant_grant", 32'(grant), 32'h9);
    check("regrant_unit_p0", 32'(grant_unit[0]), 32'h0);
    check("regrant_busy", 32'(unit_busy), 32'h3);

    // flush with both units busy while port2 requests
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_grant", 32'(grant), 32'h0);
    check("flush_busy", 32'(unit_busy), 32'h0);
    step();
    req_valid = '0;
    check("postflush_grant", 32'(grant), 32'h4);
    check("postflush_unit_p2", 32'(grant_unit[2]), 32'h0);
    lock_release = 4'b0100;
    step();
    lock_release = '0;
    check("clean1_grant", 32'(grant), 32'h0);

    // wrap: unit0 held by port3, then id 14 vs id 1 for the last unit
    req_id[3] = 4'd0; req_valid = 4'b1000;
    step();
    req_id[0] = 4'd14; req_id[1] = 4'd1; req_valid = 4'b0011;
    step();
    req_valid = 4'b0010;
    check("wrap_grant", 32'(grant), 32'h9);
    check("wrap_unit_p0", 32'(grant_unit[0]), 32'h1);
    step();
    check("full_wait", 32'(grant), 32'h9);

    // both released at once; waiting port1 only gets a unit the cycle after
    lock_release = 4'b1001;
    step();
    lock_release = '0;
    check("free_same_cycle", 32'(grant), 32'h0);
    check("free_busy", 32'(unit_busy), 32'h0);
    step();
    req_valid = '0;
    check("late_grant", 32'(grant), 32'h2);
    check("late_unit_p1", 32'(grant_unit[1]), 32'h0);
    lock_release = 4'b0010;
    step();
    lock_release = '0;

    // release from a non-holder is ignored
    lock_release = 4'b0001;
    step();
    lock_release = '0;
    check("stray_release", 32'(grant), 32'h0);

    // tie: unit0 taken by port0, ports 2 and 3 both id 6 -> port2
    req_id[0] = 4'd0; req_valid = 4'b0001;
    step();
    req_id[2] = 4'd6; req_id[3] = 4'd6; req_valid = 4'b1100;
    step();
    check("tie_grant", 32'(grant), 32'h5);
    check("tie_unit_p2", 32'(grant_unit[2]), 32'h1);

    // asynchronous reset in the middle of a cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", 32'(grant), 32'h0);
    check("async_rst_busy", 32'(unit_busy), 32'h0);
    req_valid = '0;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_grant", 32'(grant), 32'h0);

`ifdef RESOURCE_LOCK_TIMEOUT_EN
    // watchdog: counter 0 at grant, reaches 8 after 8 busy cycles, reclaimed next edge
    req_id[0] = 4'd2; req_valid = 4'b0001;
    step();
    req_valid = '0;
    check("to_grant", 32'(grant), 32'h1);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("to_hold_%0d", i), 32'({grant[0], timeout_err}), 32'h2);
    end
    step();
    check("to_pulse", 32'(timeout_err), 32'h1);
    check("to_grant_drop", 32'(grant), 32'h0);
    check("to_busy_drop", 32'(unit_busy), 32'h0);
    step();
    check("to_pulse_end", 32'(timeout_err), 32'h0);
`else
    // without the watchdog a lock outlives any timeout
    req_id[0] = 4'd2; req_valid = 4'b0001;
    step();
    req_valid = '0;
    for (int i = 0; i < 12; i++) step();
    check("nto_grant", 32'(grant), 32'h1);
    check("nto_terr", 32'(timeout_err), 32'h0);
    lock_release = 4'b0001;
    step();
    lock_release = '0;
    check("nto_release", 32'(grant), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog on the whole run
  initial begin
    #20000;
    $display("FAIL sim_timeout: simulation did not finish within 20000 ns");
    $fatal(1);
  end

endmodule
